// File: rtl/fetch_line_buffer_pkg.sv
// Shared types for the fetch line buffer: line/fetch/PC widths, line tag and
// refill sequencer states.
package fetch_line_buffer_pkg;

  localparam int unsigned CL_WIDTH         = 256;
  localparam int unsigned FD_WIDTH         = 64;
  localparam int unsigned PC_WIDTH         = 32;
  localparam int unsigned LINE_OFFSET_BITS = 5;

  typedef logic [CL_WIDTH-1:0]                  cacheline_t;
  typedef logic [FD_WIDTH-1:0]                  fetch_data_t;
  typedef logic [PC_WIDTH-1:0]                  program_counter_t;
  typedef logic [PC_WIDTH-LINE_OFFSET_BITS-1:0] line_tag_t;

  typedef enum logic [1:0] {
    FB_READY,
    FB_REQ,
    FB_WAIT,
    FB_DRAIN
  } fetch_buf_state_t;

  function automatic line_tag_t pc_tag(program_counter_t pc);
    return pc[PC_WIDTH-1:LINE_OFFSET_BITS];
  endfunction

endpackage

// File: rtl/fetch_line_buffer_extract.sv
// Doubleword selector: picks the 64-bit fetch word out of a 256-bit line
// using PC bits [4:3].
module extract_fetch_data
  import fetch_line_buffer_pkg::*;
(
  input  cacheline_t  line,
  input  logic [1:0]  dword_idx,
  output fetch_data_t data
);

  always_comb begin
    data = line[dword_idx*FD_WIDTH +: FD_WIDTH];
  end

endmodule

// File: rtl/fetch_line_buffer.sv
// Single-entry instruction line buffer with refill sequencer between fetch and
// the I-cache; a flush invalidates the line and drains any outstanding refill.
module fetch_line_buffer
  import fetch_line_buffer_pkg::*;
#(
  parameter int unsigned CACHELINE_WIDTH  = 256,
  parameter int unsigned FETCH_DATA_WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_fetch_valid,
  input  program_counter_t i_fetch_pc,
  output logic             o_fetch_ready,
  output logic             o_data_valid,
  output fetch_data_t      o_data,
  output program_counter_t o_data_pc,
  output logic             o_line_req_valid,
  output program_counter_t o_line_req_addr,
  input  logic             i_line_req_ready,
  input  logic             i_line_resp_valid,
  input  cacheline_t       i_line_resp_data
);

  if (CACHELINE_WIDTH != CL_WIDTH || FETCH_DATA_WIDTH != FD_WIDTH) begin : g_bad_cfg
    $error("fetch_line_buffer: only CACHELINE_WIDTH=256, FETCH_DATA_WIDTH=64 supported");
  end

  fetch_buf_state_t state, state_nxt;
  cacheline_t       buf_line;
  line_tag_t        buf_tag;
  logic             buf_valid;
  program_counter_t miss_pc;

  logic             hit;
  logic             accept;
  logic             hit_fire;
  logic             fill;
  cacheline_t       sel_line;
  program_counter_t sel_pc;
  fetch_data_t      sel_data;

  assign hit      = buf_valid && (buf_tag == pc_tag(i_fetch_pc));
  assign accept   = (state == FB_READY) && i_fetch_valid && !i_flush;
  assign hit_fire = accept && hit;
  assign fill     = (state == FB_WAIT) && i_line_resp_valid && !i_flush;

  // One selector serves both hit reads and refill bypass; WAIT picks the refill.
  assign sel_line = (state == FB_WAIT) ? i_line_resp_data : buf_line;
  assign sel_pc   = (state == FB_WAIT) ? miss_pc : i_fetch_pc;

  extract_fetch_data u_extract (
    .line      (sel_line),
    .dword_idx (sel_pc[4:3]),
    .data      (sel_data)
  );

  always_comb begin
    state_nxt        = state;
    o_fetch_ready    = 1'b0;
    o_line_req_valid = 1'b0;
    unique case (state)
      FB_READY: begin
        o_fetch_ready = !i_flush;
        if (accept && !hit) state_nxt = FB_REQ;
      end
      FB_REQ: begin
        o_line_req_valid = 1'b1;
        if (i_line_req_ready)  state_nxt = i_flush ? FB_DRAIN : FB_WAIT;
        else if (i_flush)      state_nxt = FB_READY;
      end
      FB_WAIT: begin
        if (i_line_resp_valid) state_nxt = FB_READY;
        else if (i_flush)      state_nxt = FB_DRAIN;
      end
      FB_DRAIN: begin
        if (i_line_resp_valid) state_nxt = FB_READY;
      end
      default: state_nxt = FB_READY;
    endcase
  end

  assign o_line_req_addr = {pc_tag(miss_pc), {LINE_OFFSET_BITS{1'b0}}};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= FB_READY;
      buf_line     <= '0;
      buf_tag      <= '0;
      buf_valid    <= 1'b0;
      miss_pc      <= '0;
      o_data_valid <= 1'b0;
      o_data       <= '0;
      o_data_pc    <= '0;
    end else begin
      state        <= state_nxt;
      o_data_valid <= hit_fire || fill;
      if (hit_fire || fill) begin
        o_data    <= sel_data;
        o_data_pc <= sel_pc;
      end
      if (accept && !hit) miss_pc <= i_fetch_pc;
      if (i_flush) begin
        buf_valid <= 1'b0;
      end else if (fill) begin
        buf_line  <= i_line_resp_data;
        buf_tag   <= pc_tag(miss_pc);
        buf_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Self-checking bench for fetch_line_buffer: directed scenarios then random
// traffic, all checked against a transaction-level model of the buffer.
module tb_fetch_line_buffer;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_flush = 1'b0;
  logic         i_fetch_valid = 1'b0;
  logic [31:0]  i_fetch_pc = '0;
  logic         o_fetch_ready;
  logic         o_data_valid;
  logic [63:0]  o_data;
  logic [31:0]  o_data_pc;
  logic         o_line_req_valid;
  logic [31:0]  o_line_req_addr;
  logic         i_line_req_ready = 1'b0;
  logic         i_line_resp_valid = 1'b0;
  logic [255:0] i_line_resp_data = '0;

  always #5 i_clk = ~i_clk;

  fetch_line_buffer #(.CACHELINE_WIDTH(256), .FETCH_DATA_WIDTH(64)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_flush           (i_flush),
    .i_fetch_valid     (i_fetch_valid),
    .i_fetch_pc        (i_fetch_pc),
    .o_fetch_ready     (o_fetch_ready),
    .o_data_valid      (o_data_valid),
    .o_data            (o_data),
    .o_data_pc         (o_data_pc),
    .o_line_req_valid  (o_line_req_valid),
    .o_line_req_addr   (o_line_req_addr),
    .i_line_req_ready  (i_line_req_ready),
    .i_line_resp_valid (i_line_resp_valid),
    .i_line_resp_data  (i_line_resp_data)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: buffer contents plus the outstanding-refill bookkeeping.
  bit           m_bvalid;
  logic [26:0]  m_btag;
  logic [255:0] m_bline;
  bit           m_req_pending;
  bit           m_resp_owed;
  bit           m_discard;
  logic [31:0]  m_miss_pc;
  bit           m_dv;
  logic [63:0]  m_data;
  logic [31:0]  m_dpc;

  task automatic model_reset();
    m_bvalid = 0; m_btag = '0; m_bline = '0;
    m_req_pending = 0; m_resp_owed = 0; m_discard = 0;
    m_miss_pc = '0; m_dv = 0; m_data = '0; m_dpc = '0;
  endtask

  task automatic step(input bit fl, input bit fv, input logic [31:0] pc,
                      input bit lrr, input bit rv, input logic [255:0] rd);
    bit idle, accept, hit;
    @(negedge i_clk);
    i_flush = fl; i_fetch_valid = fv; i_fetch_pc = pc;
    i_line_req_ready = lrr; i_line_resp_valid = rv; i_line_resp_data = rd;
    #1;
    idle = !m_req_pending && !m_resp_owed;
    check("fetch_ready", {63'd0, o_fetch_ready}, {63'd0, idle && !fl});
    check("req_valid", {63'd0, o_line_req_valid}, {63'd0, m_req_pending});
    if (m_req_pending) check("req_addr", {32'd0, o_line_req_addr}, {32'd0, m_miss_pc[31:5], 5'd0});

    accept = idle && fv && !fl;
    hit    = m_bvalid && (m_btag == pc[31:5]);
    m_dv   = 0;
    if (accept && hit) begin
      m_dv = 1; m_data = m_bline[pc[4:3]*64 +: 64]; m_dpc = pc;
    end
    if (m_resp_owed) begin
      if (rv) begin
        m_resp_owed = 0;
        if (!m_discard && !fl) begin
          m_bline = rd; m_btag = m_miss_pc[31:5]; m_bvalid = 1;
          m_dv = 1; m_data = rd[m_miss_pc[4:3]*64 +: 64]; m_dpc = m_miss_pc;
        end
      end else if (fl) begin
        m_discard = 1;
      end
    end
    if (m_req_pending) begin
      if (lrr) begin
        m_req_pending = 0; m_resp_owed = 1; m_discard = fl;
      end else if (fl) begin
        m_req_pending = 0;
      end
    end
    if (accept && !hit) begin
      m_req_pending = 1; m_miss_pc = pc;
    end
    if (fl) m_bvalid = 0;

    @(posedge i_clk);
    #1;
    check("data_valid", {63'd0, o_data_valid}, {63'd0, m_dv});
    check("data", o_data, m_data);
    check("data_pc", {32'd0, o_data_pc}, {32'd0, m_dpc});
  endtask

  task automatic idle_step();
    step(0, 0, 32'h0, 0, 0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dv"},    {63'd0, o_data_valid},     64'd0);
    check({tag, "_data"},  o_data,                    64'd0);
    check({tag, "_pc"},    {32'd0, o_data_pc},        64'd0);
    check({tag, "_rqv"},   {63'd0, o_line_req_valid}, 64'd0);
    check({tag, "_rqa"},   {32'd0, o_line_req_addr},  64'd0);
    check({tag, "_ready"}, {63'd0, o_fetch_ready},    64'd1);
  endtask

  logic [255:0] line0, line1, line2, rnd_line;
  logic [31:0]  rpc;

  initial begin
    for (int k = 0; k < 4; k++) begin
      line0[k*64 +: 64] = 64'h1111_0000_0000_0000 | 64'(k);
      line1[k*64 +: 64] = 64'h2222_0000_0000_0000 | 64'(k);
      line2[k*64 +: 64] = 64'h3333_0000_0000_0000 | 64'(k);
    end
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge i_clk);
    i_rst = 1'b0;

    // Cold miss to 0x1000: handshake at +3, response at +5.
    step(0, 1, 32'h1000, 0, 0, '0);
    check("miss_addr_1000", {32'd0, o_line_req_addr}, 64'h1000);
    idle_step();
    idle_step();
    step(0, 0, 32'h0, 1, 0, '0);
    idle_step();
    step(0, 0, 32'h0, 0, 1, line0);
    check("first_data", o_data, 64'h1111_0000_0000_0000);

    step(0, 1, 32'h1008, 0, 0, '0);
    step(0, 1, 32'h1010, 0, 0, '0);
    step(0, 1, 32'h1018, 0, 0, '0);
    check("hit_dw3", o_data, 64'h1111_0000_0000_0003);

    // Replace the line with 0x1020, then 0x1000 must miss again.
    step(0, 1, 32'h1028, 0, 0, '0);
    check("miss_addr_1020", {32'd0, o_line_req_addr}, 64'h1020);
    step(0, 0, 32'h0, 1, 0, '0);
    step(0, 0, 32'h0, 0, 1, line1);
    step(0, 1, 32'h1000, 0, 0, '0);
    check("tag_replaced", {63'd0, o_line_req_valid}, 64'd1);
    step(0, 0, 32'h0, 1, 0, '0);
    // Flush in WAIT, then the response is dropped.
    step(1, 0, 32'h0, 0, 0, '0);
    step(0, 1, 32'h1000, 0, 1, line0);
    step(0, 1, 32'h1000, 0, 0, '0);
    check("refetch_miss", {63'd0, o_line_req_valid}, 64'd1);
    step(0, 0, 32'h0, 1, 0, '0);
    step(0, 0, 32'h0, 0, 1, line0);

    // Flush in REQ together with ready: drain.
    step(0, 1, 32'h2000, 0, 0, '0);
    step(1, 1, 32'h2000, 1, 0, '0);
    step(0, 1, 32'h2000, 0, 0, '0);
    step(1, 1, 32'h2000, 0, 0, '0);
    step(0, 1, 32'h2000, 0, 1, line2);
    // Flush in REQ without ready: straight back to READY.
    step(0, 1, 32'h2008, 0, 0, '0);
    step(1, 0, 32'h0, 0, 0, '0);
    step(0, 1, 32'h1000, 0, 0, '0);

    // Async reset while in WAIT.
    step(0, 0, 32'h0, 1, 0, '0);
    @(negedge i_clk);
    i_line_req_ready = 0; i_line_resp_valid = 0; i_fetch_valid = 0; i_flush = 0;
    i_rst = 1'b1;
    #1;
    check_reset_outputs("mid_wait_reset");
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    step(0, 1, 32'h1000, 0, 0, '0);
    check("post_reset_miss", {63'd0, o_line_req_valid}, 64'd1);

    for (int c = 0; c < 3000; c++) begin
      for (int w = 0; w < 8; w++) rnd_line[w*32 +: 32] = $urandom;
      rpc = 32'h1000 + ($urandom_range(0, 3) << 5) + ($urandom_range(0, 3) << 3);
      step(($urandom % 20) == 0, ($urandom % 4) != 0, rpc,
           m_req_pending && (($urandom % 2) == 0),
           m_resp_owed && (($urandom % 3) == 0), rnd_line);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_line_buffer.md
# fetch_line_buffer

Single-entry instruction line buffer and refill sequencer between the fetch stage and the I-cache. It holds one 256-bit cacheline and serves 64-bit fetch requests from it on a hit. On a miss it issues a line request to the I-cache, waits for the line, fills the buffer and then returns the fetch data. A flush from redirect/branch-recovery invalidates the buffer and cleanly drains any outstanding refill.

## Interface
Parameters (configuration macros from config.svh; only this combination is supported, anything else is an elaboration `$error`):
- `CACHELINE_WIDTH`, 256: line width in bits (32 bytes).
- `FETCH_DATA_WIDTH`, 64: fetch width in bits (8 bytes).

Ports:
- `i_clk`  in  1  clock; single clock domain.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_flush`  in  1  invalidate buffer, abort or drain any refill, drop pending response.
- `i_fetch_valid`  in  1  fetch request valid.
- `i_fetch_pc`  in  program_counter_t  fetch PC.
- `o_fetch_ready`  out  1  request accepted when `i_fetch_valid && o_fetch_ready`.
- `o_data_valid`  out  1  one-cycle pulse; fetch data valid.
- `o_data`  out  fetch_data_t  64-bit fetch data.
- `o_data_pc`  out  program_counter_t  PC of the returned data.
- `o_line_req_valid`  out  1  refill request to the I-cache.
- `o_line_req_addr`  out  program_counter_t  line-aligned address, `{pc[W-1:5], 5'b0}`.
- `i_line_req_ready`  in  1  I-cache accepts the refill request.
- `i_line_resp_valid`  in  1  refill line valid, one-cycle pulse.
- `i_line_resp_data`  in  cacheline_t  refill line.

## Operation
- Storage: `buf_line` (cacheline_t), `buf_tag` (`pc[W-1:5]`), `buf_valid`, `miss_pc`.
- Hit: `buf_valid && buf_tag == i_fetch_pc[W-1:5]`.
- **READY**
  - `o_fetch_ready = !i_flush`.
  - Accepted hit: stay in READY. Next cycle assert `o_data_valid` with `o_data` = the `pc[4:3]` doubleword of `buf_line` and `o_data_pc` = the PC. Back-to-back hits are supported, one per cycle.
  - Accepted miss: latch `miss_pc`, go to REQ.
- **REQ**
  - `o_line_req_valid = 1`; address held stable until `i_line_req_ready`.
  - On `i_line_req_ready`: go to WAIT.
- **WAIT**
  - On `i_line_resp_valid`: write `buf_line`, `buf_tag` from `miss_pc`, and set `buf_valid`. Register `o_data` and `o_data_pc` from the new line and `miss_pc`, and pulse `o_data_valid` next cycle. Go to READY.
- **DRAIN**
  - On `i_line_resp_valid`: discard the line (buffer not written), go to READY.
- `o_fetch_ready = 0` in REQ, WAIT and DRAIN.
- **Flush**
  - Clears `buf_valid` and suppresses any `o_data_valid` due next cycle.
  - In READY: no request is accepted that cycle.
  - REQ without `i_line_req_ready`: go to READY; the request is withdrawn.
  - REQ with `i_line_req_ready` in the same cycle: the request counts as issued, go to DRAIN.
  - WAIT without response: go to DRAIN.
  - WAIT with `i_line_resp_valid` in the same cycle: discard the line, go to READY.
  - DRAIN: stay in DRAIN (idempotent).
- Reset mid-refill returns to READY. The I-cache is reset in the same domain, so no stale response arrives after reset.
- Reset values: state READY, `buf_valid = 0`, `o_data_valid = 0`, `o_data = 0`, `o_data_pc = 0`, `o_line_req_valid = 0`, `o_line_req_addr = 0`, `o_fetch_ready = 1`.

## Timing
- Hit latency: 1 cycle. Accept at T, `o_data_valid` at T+1.
- Miss: accept at T, `o_line_req_valid` from T+1. If the request handshakes at cycle H and the response arrives at cycle R (R > H), `o_data_valid` rises at R+1 and `o_fetch_ready` returns at R+1.
- Outputs are registered, except `o_fetch_ready`, which is a decode of state and `i_flush`.
- `o_line_req_valid` and `o_line_req_addr` are state decodes; no combinational path from `i_line_req_ready`.

## Structure
- Add `fetch_buf_state_t` (READY/REQ/WAIT/DRAIN) and `line_tag_t` to caches.svh.
- Reuse `cacheline_t`, `fetch_data_t` and `program_counter_t` from the existing headers.
- Sub-module: one instance of the existing `extract_fetch_data` selector.
  - Line input muxed between `buf_line` (hit) and `i_line_resp_data` (refill).
  - PC input muxed between `i_fetch_pc` and `miss_pc`.

## Test plan
- Reset, then fetch `0x1000`: miss, `o_line_req_addr = 0x1000`. Ready at +3, response at +5 with doubleword k = `64'h1111_0000_0000_000k`. Required: `o_data_valid` at +6 with `o_data = 64'h1111_0000_0000_0000`.
- Back-to-back fetches `0x1008`, `0x1010`, `0x1018` after the fill: three consecutive `o_data_valid` pulses with doublewords 1, 2, 3 and no line request.
- Fetch `0x1020` after the `0x1000` fill: miss, `o_line_req_addr = 0x1020`, and the buffer tag is replaced on response.
- Flush while in WAIT, then response: no `o_data_valid` and `buf_valid = 0`. The next fetch to `0x1000` misses.
- Flush in REQ in the same cycle as `i_line_req_ready`: enter DRAIN, `o_fetch_ready = 0` until the response, which is discarded. Flush in REQ without ready: READY next cycle, no drain.
- `i_rst` asserted mid-WAIT: all outputs return to reset values immediately (asynchronous). The first fetch after release misses.
